data_mem_responder: RTL and testbench

//  Multi-cycle responder for the datapath's data-memory port: accepts one word read/write

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_array.sv | 33 +++
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder.
// State encoding and latency counter width.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Wide enough for LATENCY values 0..15.
    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Word storage for the responder.
// One synchronous write port, one synchronous read port, no reset.
module mem_array #(
    parameter int DEPTH_LOG2 = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage write and registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder.
// Accepts one request, waits LATENCY cycles, returns one response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5,
    parameter int LATENCY    = 2,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    state_t r_state;
    state_t w_next;

    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_next;

    logic              r_we;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic                  w_accept;
    logic                  w_cur_we;
    logic [31:0]           w_cur_addr;
    logic [DATA_W-1:0]     w_cur_wdata;
    logic                  w_err;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_enter_resp;
    logic                  w_arr_we;
    logic                  w_arr_re;
    logic [DATA_W-1:0]     w_arr_rdata;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // With zero latency RESP is entered on the accept edge itself,
    // so the incoming request is used before it reaches the latch.
    assign w_cur_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_cur_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_err = (|w_cur_addr[1:0])
                || (|w_cur_addr[31:DEPTH_LOG2+2]);
    assign w_idx = w_cur_addr[DEPTH_LOG2+1:2];

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_arr_we     = w_enter_resp && w_cur_we && !w_err;
    assign w_arr_re     = w_enter_resp && !w_cur_we && !w_err;

    mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_waddr (w_idx),
        .i_wdata (w_cur_wdata),
        .i_re    (w_arr_re),
        .i_raddr (w_idx),
        .o_rdata (w_arr_rdata)
    );

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: the counter is loaded with LATENCY and RESP follows
    // the edge on which it decrements to zero.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = LAT_W'(LATENCY);
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == LAT_W'(1)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // Capture the request on accept so inputs may change afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Response pulse registered out of RESP; data and error are
    // forced to zero whenever no response is being presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else if (r_state == S_RESP) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_rdata <= (!r_we && !w_err) ? w_arr_rdata : '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of requests with a
// response scoreboard, plus back-to-back and reset sequences.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        z_valid = 1'b0;
    logic        z_we = 1'b0;
    logic [31:0] z_addr = '0;
    logic [31:0] z_wdata = '0;
    logic        z_ready;
    logic        z_resp_valid;
    logic [31:0] z_resp_rdata;
    logic        z_resp_err;

    data_mem_responder #(
        .DEPTH_LOG2 (5),
        .LATENCY    (LAT),
        .DATA_W     (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    data_mem_responder #(
        .DEPTH_LOG2 (5),
        .LATENCY    (0),
        .DATA_W     (32)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (z_valid),
        .req_we     (z_we),
        .req_addr   (z_addr),
        .req_wdata  (z_wdata),
        .req_ready  (z_ready),
        .resp_valid (z_resp_valid),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[10];

    int          z_pcyc[$];
    logic [31:0] z_pdat[$];
    logic        z_perr[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop and compare each response, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    chk("resp_cycle", cyc, e.due);
                end
            end else begin
                chk("idle_rdata", resp_rdata, 32'd0);
                chk("idle_err", {31'b0, resp_err}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && z_resp_valid) begin
            z_pcyc.push_back(cyc);
            z_pdat.push_back(z_resp_rdata);
            z_perr.push_back(z_resp_err);
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic e_err,
                         input logic [31:0] e_rd, input bit push);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else if (push) begin
            sb.push_back('{rdata: e_rd, err: e_err, due: cyc + LAT + 2});
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int low;
        int acc_cyc[3];
        int z_first;
        logic [31:0] rd_addr[3];
        logic [31:0] rd_val[3];

        tbl[0] = '{1'b1, 32'h0000000C, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h0000000C, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 32'h00000004, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 32'h00000006, 32'h11111111, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 32'h00000004, 32'h0,        1'b0, 32'hCAFEF00D};
        tbl[5] = '{1'b0, 32'h00000080, 32'h0,        1'b1, 32'h0};
        tbl[6] = '{1'b1, 32'h0000007C, 32'hA5A55A5A, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 32'h0000007C, 32'h0,        1'b0, 32'hA5A55A5A};
        tbl[8] = '{1'b1, 32'h00000010, 32'h12345678, 1'b0, 32'h0};
        tbl[9] = '{1'b0, 32'h10000010, 32'h0,        1'b1, 32'h0};

        // Reset held three cycles.
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("post_rst_rdata", resp_rdata, 32'd0);

        // Table of single requests.
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].we, tbl[i].addr, tbl[i].wdata,
                  tbl[i].err, tbl[i].rd, 1'b1);
            drain();
        end

        // Valid held high across three reads.
        rd_addr[0] = 32'h0C; rd_val[0] = 32'hDEADBEEF;
        rd_addr[1] = 32'h04; rd_val[1] = 32'hCAFEF00D;
        rd_addr[2] = 32'h7C; rd_val[2] = 32'hA5A55A5A;
        acc = 0;
        low = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int k = 0; k < 40 && acc < 3; k++) begin
            req_addr = rd_addr[acc];
            if (req_ready) begin
                sb.push_back('{rdata: rd_val[acc], err: 1'b0,
                               due: cyc + LAT + 2});
                acc_cyc[acc] = cyc + 1;
                acc++;
            end else if (acc > 0) begin
                low++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_accepts", acc, 32'd3);
        chk("b2b_ready_low", low, 2 * (LAT + 1));
        chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], LAT + 2);
        chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], LAT + 2);
        drain();

        // Zero-latency instance: three writes then three reads.
        z_first = 0;
        for (int ph = 0; ph < 2; ph++) begin
            acc = 0;
            z_valid = 1'b1;
            z_we    = (ph == 0);
            for (int k = 0; k < 20 && acc < 3; k++) begin
                z_addr  = 32'(4 * acc);
                z_wdata = 32'h100 + 32'(acc);
                if (z_ready) begin
                    if (ph == 1 && acc == 0) z_first = cyc + 1;
                    acc++;
                end
                @(negedge clk);
            end
            z_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
        chk("z_pulses", z_pcyc.size(), 32'd6);
        if (z_pcyc.size() == 6) begin
            chk("z_wgap1", z_pcyc[1] - z_pcyc[0], 32'd2);
            chk("z_wgap2", z_pcyc[2] - z_pcyc[1], 32'd2);
            chk("z_rgap1", z_pcyc[4] - z_pcyc[3], 32'd2);
            chk("z_rgap2", z_pcyc[5] - z_pcyc[4], 32'd2);
            chk("z_rlat", z_pcyc[3], z_first + 1);
            for (int i = 0; i < 3; i++) begin
                chk("z_wack", z_pdat[i], 32'd0);
                chk("z_rdata", z_pdat[3 + i], 32'h100 + 32'(i));
                chk("z_err", {31'b0, z_perr[3 + i]}, 32'd0);
            end
        end

        // Reset during WAIT drops the pending write.
        issue(1'b1, 32'h10, 32'hBADBAD00, 1'b0, 32'h0, 1'b0);
        chk("mid_state_wait", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        issue(1'b0, 32'h10, 32'h0, 1'b0, 32'h12345678, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
